// File: rtl/dg0045_rom_server_if.sv
// Fetch/load bus between the DG0045 core-side ROM server and its neighbours.
// slave: the ROM server; master: core/bench side driving pc_hl and the load port.
interface dg0045_rom_server_if;
  logic [4:0] pc_hl;
  logic       pc_mux;
  logic [7:0] rom_data;
  logic [9:0] fetch_addr;
  logic       fetch_done;
  logic       load_valid;
  logic       load_ready;
  logic [9:0] load_addr;
  logic [7:0] load_data;
  logic       parity_err;

  modport slave (
    input  pc_hl, load_valid, load_addr, load_data,
    output pc_mux, rom_data, fetch_addr, fetch_done, load_ready, parity_err
  );

  modport master (
    output pc_hl, load_valid, load_addr, load_data,
    input  pc_mux, rom_data, fetch_addr, fetch_done, load_ready, parity_err
  );
endinterface

// File: rtl/dg0045_rom_server.sv
// Program-ROM responder for the DG0045 multiplexed fetch: assembles the 10-bit PC
// from two pc_hl halves and returns the opcode. Optional macro: ROM_SERVER_PARITY_EN.
module dg0045_rom_server #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned DEPTH      = 1024
) (
  input logic                clk,
  input logic                rst_n,
  dg0045_rom_server_if.slave bus
);

`ifdef ROM_SERVER_PARITY_EN
  localparam int unsigned WORD_W = 9;
`else
  localparam int unsigned WORD_W = 8;
`endif
  localparam logic [2:0] CNT_LAST = 3'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {S_LO, S_HI, S_FETCH} state_t;

  state_t            state;
  logic [2:0]        settle_cnt;
  logic [4:0]        lo_q;
  logic [4:0]        hi_q;
  logic [9:0]        pc_w;
  logic              pc_mux_q;
  logic              load_ready_q;
  logic              fetch_done_q;
  logic [7:0]        rom_q;
  logic [9:0]        addr_q;
  logic              load_fire;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rd_word;
`ifdef ROM_SERVER_PARITY_EN
  logic              parity_err_q;
`endif

  assign pc_w      = {hi_q, lo_q};
  assign rd_word   = mem[pc_w];
  assign load_fire = bus.load_valid & load_ready_q;

  // Store is never reset; loads are only accepted outside S_FETCH, so the read port is free then.
  always_ff @(posedge clk) begin
    if (load_fire) begin
`ifdef ROM_SERVER_PARITY_EN
      mem[bus.load_addr] <= {^bus.load_data, bus.load_data};
`else
      mem[bus.load_addr] <= bus.load_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_LO;
      settle_cnt   <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      pc_mux_q     <= 1'b0;
      load_ready_q <= 1'b1;
      fetch_done_q <= 1'b0;
      rom_q        <= '0;
      addr_q       <= '0;
`ifdef ROM_SERVER_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      fetch_done_q <= 1'b0;
      unique case (state)
        S_LO: begin
          if (settle_cnt == CNT_LAST) begin
            lo_q       <= bus.pc_hl;
            settle_cnt <= '0;
            state      <= S_HI;
            pc_mux_q   <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 3'd1;
          end
        end
        S_HI: begin
          if (settle_cnt == CNT_LAST) begin
            hi_q         <= bus.pc_hl;
            settle_cnt   <= '0;
            state        <= S_FETCH;
            load_ready_q <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + 3'd1;
          end
        end
        S_FETCH: begin
          addr_q       <= pc_w;
          fetch_done_q <= 1'b1;
          state        <= S_LO;
          pc_mux_q     <= 1'b0;
          load_ready_q <= 1'b1;
`ifdef ROM_SERVER_PARITY_EN
          // A corrupted word is replaced by NOP so the core never executes it.
          if (^rd_word) begin
            rom_q        <= '0;
            parity_err_q <= 1'b1;
          end else begin
            rom_q <= rd_word[7:0];
          end
`else
          rom_q <= rd_word;
`endif
        end
        default: begin
          state        <= S_LO;
          settle_cnt   <= '0;
          pc_mux_q     <= 1'b0;
          load_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.pc_mux     = pc_mux_q;
  assign bus.load_ready = load_ready_q;
  assign bus.fetch_done = fetch_done_q;
  assign bus.rom_data   = rom_q;
  assign bus.fetch_addr = addr_q;
`ifdef ROM_SERVER_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_dg0045_rom_server.sv
// Bench for dg0045_rom_server: slot-based model of the fetch loop plus directed vectors.
module tb_dg0045_rom_server;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned PERIOD = 2 * SETTLE + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  dg0045_rom_server_if bus ();

  dg0045_rom_server #(.SETTLE_CYC(SETTLE), .DEPTH(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;
  bit   manual = 1'b0;
  logic [9:0] tgt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int unsigned a);
    return 8'((a * 37 + 11) & 255);
  endfunction

  // Model: the loop is a fixed PERIOD-slot schedule counted from reset release.
  logic [7:0]  m_mem   [1024];
  bit          m_known [1024];
  bit          m_bad   [1024];
  int unsigned m_k;
  int unsigned m_p;
  logic [4:0]  m_lo, m_hi;
  logic [9:0]  m_addr, m_a;
  logic [7:0]  m_rom;
  logic        m_done, m_perr;
  bit          m_rom_known, m_perr_known;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_k = 0; m_lo = '0; m_hi = '0; m_addr = '0; m_rom = '0;
      m_done = 1'b0; m_perr = 1'b0; m_rom_known = 1'b1; m_perr_known = 1'b1;
    end else begin
      m_p    = m_k % PERIOD;
      m_done = 1'b0;
      if (m_p == SETTLE - 1) m_lo = bus.pc_hl;
      else if (m_p == 2 * SETTLE - 1) m_hi = bus.pc_hl;
      else if (m_p == 2 * SETTLE) begin
        m_a    = {m_hi, m_lo};
        m_addr = m_a;
        m_done = 1'b1;
        if (!m_known[m_a]) begin
          m_rom_known = 1'b0;
`ifdef ROM_SERVER_PARITY_EN
          m_perr_known = 1'b0;
`endif
        end else begin
          m_rom_known = 1'b1;
`ifdef ROM_SERVER_PARITY_EN
          if (m_bad[m_a]) begin
            m_rom  = 8'h00;
            m_perr = 1'b1;
          end else
`endif
          m_rom = m_mem[m_a];
        end
      end
      if (bus.load_valid && m_p != 2 * SETTLE) begin
        m_mem[bus.load_addr]   = bus.load_data;
        m_known[bus.load_addr] = 1'b1;
        m_bad[bus.load_addr]   = 1'b0;
      end
      m_k++;
    end
  end

  always @(negedge clk) begin
    #2;
    if (cmp_en) begin
      chk("pc_mux", 32'(bus.pc_mux), 32'((m_k % PERIOD) >= SETTLE));
      chk("load_ready", 32'(bus.load_ready), 32'((m_k % PERIOD) != 2 * SETTLE));
      chk("fetch_done", 32'(bus.fetch_done), 32'(m_done));
      chk("fetch_addr", 32'(bus.fetch_addr), 32'(m_addr));
      if (m_rom_known) chk("rom_data", 32'(bus.rom_data), 32'(m_rom));
      if (m_perr_known) chk("parity_err", 32'(bus.parity_err), 32'(m_perr));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
    if (!manual) bus.pc_hl = bus.pc_mux ? tgt[9:5] : tgt[4:0];
  endtask

  task automatic wait_phase(input int unsigned p);
    int unsigned n = 0;
    while ((m_k % PERIOD) != p && n < 12) begin
      tick();
      n++;
    end
  endtask

  task automatic load(input logic [9:0] a, input logic [7:0] d);
    int unsigned n = 0;
    bus.load_valid = 1'b1;
    bus.load_addr  = a;
    bus.load_data  = d;
    while (!bus.load_ready && n < 8) begin
      tick();
      n++;
    end
    chk("load_ready_wait", 32'(bus.load_ready), 32'd1);
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic wait_fetch(input logic [9:0] a, input string name);
    int unsigned n = 0;
    do begin
      tick();
      n++;
    end while (!(bus.fetch_done && bus.fetch_addr == a) && n < 30);
    chk(name, {21'd0, bus.fetch_done, bus.fetch_addr}, {21'd0, 1'b1, a});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.pc_hl = '0; bus.load_valid = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    cmp_en = 1'b1;
    chk("rst_pc_mux", 32'(bus.pc_mux), 32'd0);
    chk("rst_rom", 32'(bus.rom_data), 32'h00);
    chk("rst_done", 32'(bus.fetch_done), 32'd0);
    chk("rst_addr", 32'(bus.fetch_addr), 32'd0);
    rst_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.pc_mux && n < 10);
    chk("first_mux_rise", 32'(n), 32'(SETTLE));

    for (int unsigned a = 0; a < 1024; a++) load(10'(a), pat(a));
    rst_n = 1'b0;
    #1;
    chk("rst2_parity", 32'(bus.parity_err), 32'd0);
    tick();
    rst_n = 1'b1;

    // Basic fetch: 3E5 -> halves 05 (pc_mux=0) and 1F (pc_mux=1)
    load(10'h3E5, 8'hC7);
    tgt = 10'h3E5;
    wait_fetch(10'h3E5, "basic_addr");
    chk("basic_rom", 32'(bus.rom_data), 32'hC7);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("basic_hold_rom", 32'(bus.rom_data), 32'hC7);
      chk("basic_hold_done", 32'(bus.fetch_done), 32'd0);
    end

    // Settle window: only the final-cycle sample of lo counts
    wait_phase(0);
    manual = 1'b1;
    bus.pc_hl = 5'h00;
    tick();
    bus.pc_hl = 5'h11;
    tick();
    bus.pc_hl = 5'h0A;
    tick();
    tick();
    manual = 1'b0;
    tick();
    chk("settle_done", 32'(bus.fetch_done), 32'd1);
    chk("settle_addr", 32'(bus.fetch_addr), 32'h151);
    chk("settle_rom", 32'(bus.rom_data), 32'hC0);

    // Load/fetch collision
    tgt = 10'h3E5;
    wait_fetch(10'h3E5, "coll_pre");
    wait_phase(2);
    bus.load_valid = 1'b1; bus.load_addr = 10'h2AA; bus.load_data = 8'h3C;
    tick();
    bus.load_addr = 10'h155; bus.load_data = 8'h96;
    tick();
    bus.load_addr = 10'h0F0; bus.load_data = 8'hA5;
    chk("coll_ready_fetch", 32'(bus.load_ready), 32'd0);
    tick();
    chk("coll_fetch_done", 32'(bus.fetch_done), 32'd1);
    chk("coll_fetch_rom", 32'(bus.rom_data), 32'hC7);
    chk("coll_ready_lo", 32'(bus.load_ready), 32'd1);
    tick();
    bus.load_valid = 1'b0;
    tgt = 10'h0F0;
    wait_fetch(10'h0F0, "coll_addr_c");
    chk("coll_rom_c", 32'(bus.rom_data), 32'hA5);
    tgt = 10'h2AA;
    wait_fetch(10'h2AA, "coll_addr_a");
    chk("coll_rom_a", 32'(bus.rom_data), 32'h3C);

    // Overwrite the address being assembled
    load(10'h000, 8'h00);
    tgt = 10'h000;
    wait_fetch(10'h000, "ow_addr0");
    chk("ow_rom0", 32'(bus.rom_data), 32'h00);
    wait_phase(2);
    bus.load_valid = 1'b1; bus.load_addr = 10'h000; bus.load_data = 8'h5E;
    tick();
    bus.load_valid = 1'b0;
    wait_fetch(10'h000, "ow_addr1");
    chk("ow_rom1", 32'(bus.rom_data), 32'h5E);

    // Reset mid-S_HI and mid-S_FETCH; store survives
    tgt = 10'h3E5;
    wait_fetch(10'h3E5, "rhi_pre");
    wait_phase(3);
    rst_n = 1'b0;
    #1;
    chk("rhi_rom", 32'(bus.rom_data), 32'h00);
    chk("rhi_mux", 32'(bus.pc_mux), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    wait_fetch(10'h3E5, "retain_addr");
    chk("retain_rom", 32'(bus.rom_data), 32'hC7);
    wait_phase(4);
    rst_n = 1'b0;
    #1;
    chk("rfetch_rom", 32'(bus.rom_data), 32'h00);
    chk("rfetch_done", 32'(bus.fetch_done), 32'd0);
    tick();
    rst_n = 1'b1;
    wait_fetch(10'h3E5, "rfetch_addr");
    chk("rfetch_rom2", 32'(bus.rom_data), 32'hC7);

`ifdef ROM_SERVER_PARITY_EN
    load(10'h001, 8'h5A);
    dut.mem[1][3] = ~dut.mem[1][3];
    m_bad[1] = 1'b1;
    tgt = 10'h001;
    wait_fetch(10'h001, "par_addr");
    chk("par_rom", 32'(bus.rom_data), 32'h00);
    chk("par_err", 32'(bus.parity_err), 32'd1);
    tgt = 10'h3E5;
    wait_fetch(10'h3E5, "par_clean_addr");
    chk("par_clean_rom", 32'(bus.rom_data), 32'hC7);
    chk("par_sticky", 32'(bus.parity_err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("par_clear", 32'(bus.parity_err), 32'd0);
    tick();
    rst_n = 1'b1;
`endif

    repeat (PERIOD) tick();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
